md_bus_front: RTL and testbench
===============================

Name: md_bus_front

Overview:
- Upstream front end between raw Mega Drive cartridge-bus pins and the cart core.
- Synchronises asynchronous 68k/Z80 bus strobes into the 50 MHz system domain.
- Classifies each bus cycle as read or write and issues a single-cycle request with latched address, data and byte enables.
- Returns read data to the bus with output-enable and DTACK timing, so the core never handles pin-level asynchrony.

Parameters:
- SYNC_STAGES, 2: flip-flop stages per strobe synchroniser (min 2).
- SETTLE_CYC, 2: clk cycles after synchronised AS fall before address/strobes are sampled.
- ACK_TIMEOUT, 32: clk cycles to wait for core ack before forcing a timeout completion.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- md_addr  in  23  MD_A[23:1], unsynchronised
- md_dato  in  16  data driven by the console
- md_as_n, md_cas_n, md_ce_lo_n, md_ce_hi_n, md_oe_n, md_we_lo_n, md_we_hi_n  in  1 each  raw bus strobes
- md_dati  out  16  data to drive onto the bus
- md_bus_oe  out  1  enables the bus driver toward the console
- md_dtak  out  1  DTACK request, active high
- req_rd  out  1  one-cycle read request pulse
- req_wr  out  1  one-cycle write request pulse
- req_addr  out  24  byte address {md_addr,1'b0}
- req_data  out  16  latched write data
- req_be  out  2  byte enables [1]=hi, [0]=lo
- req_region  out  2  0=CE_LO, 1=CE_HI, 2=CAS only, 3=other
- core_ack  in  1  core completion strobe (one cycle)
- core_rdata  in  16  read data, valid with core_ack
- err_timeout  out  1  one-cycle pulse on ack timeout
- err_abort  out  1  one-cycle pulse when AS releases before ack

Behaviour:
- Reset: all synchroniser flops reset to 1 (inactive); state IDLE; all outputs 0 except md_dati=16'h0000.
- Strobes are synchronised via SYNC_STAGES flops. md_addr and md_dato are not synchronised; they are sampled only after SETTLE.
- IDLE: on a synchronised AS falling edge, go to SETTLE and clear the counter.
- SETTLE: count SETTLE_CYC cycles, then go to DECODE.
- DECODE:
  - AS high → IDLE, no request, no error.
  - OE low with CE_LO, CE_HI or CAS low → read: latch addr/region, set req_be=2'b11, pulse req_rd, go to WAIT_ACK.
  - Any WE low → write: latch addr, data and req_be={!we_hi,!we_lo}, pulse req_wr, go to WAIT_ACK.
  - Otherwise stay in DECODE; writes assert WE late.
  - Region priority: CE_LO > CE_HI > CAS.
- WAIT_ACK:
  - Timeout counter increments each cycle.
  - On core_ack: for reads, md_dati=core_rdata. Go to HOLD.
  - On reaching ACK_TIMEOUT: md_dati=16'hFFFF, pulse err_timeout, go to HOLD.
  - If AS rises before ack: pulse err_abort once, keep waiting for ack or timeout, then go to IDLE without asserting md_bus_oe/md_dtak.
- HOLD:
  - md_dtak=1. md_bus_oe=1 only for reads while synchronised OE is low.
  - On synchronised AS rising: clear md_dtak/md_bus_oe in the same cycle the edge is detected, go to IDLE.
- core_ack outside WAIT_ACK is ignored.
- Request latency: SYNC_STAGES+SETTLE_CYC+1 cycles from pin AS fall to the req pulse (5 at defaults).
- Latched outputs hold until the next request.
- Back-to-back cycles: a new AS fall is accepted only after IDLE is reached, giving at least one idle cycle between cycles.
- Reset mid-operation: immediately returns to IDLE and drops md_dtak/md_bus_oe.

Optional Feature:
- MD_BUS_STATS_EN defined: adds outputs stat_rd, stat_wr, stat_err (16 bits each), reset to 0.
  - stat_rd and stat_wr count on req_rd and req_wr.
  - stat_err counts on err_timeout or err_abort (both in one cycle counts as 1).
  - All counters saturate at 16'hFFFF.
- Undefined: the ports and counters are absent.

Decomposition:
- Package md_bus_pkg: state enum (IDLE, SETTLE, DECODE, WAIT_ACK, HOLD), region enum, constant TIMEOUT_DATA=16'hFFFF.
- Sub-module md_sync_edge: SYNC_STAGES synchroniser with reset-to-1 and fall/rise pulse outputs. Instantiated per strobe; level and edges are used for AS, levels only for the others.

Test Plan:
- Read: AS and CE_LO low with addr 23'h000100, then OE low; core_ack after 3 cycles with 16'hA55A → req_rd with req_addr=24'h000200, region 0, be 2'b11; md_bus_oe=1, md_dati=16'hA55A, md_dtak=1 until AS rises.
- Byte write: AS low, CE_HI low, WE_LO low, data 16'h00C3 → req_wr, req_be=2'b01, req_data=16'h00C3, region 1; no md_bus_oe.
- Timeout: read with no core_ack → err_timeout exactly ACK_TIMEOUT cycles after req_rd; md_dati=16'hFFFF; md_dtak held until AS rises.
- Abort: AS rises 2 cycles after req_wr; ack arrives 4 cycles later → one err_abort pulse, md_dtak never asserted, return to IDLE.
- Glitch: AS low for 1 cycle only, then high → no request and no error pulse.
- Reset: rst_n low during HOLD → md_dtak and md_bus_oe drop asynchronously; with MD_BUS_STATS_EN the counters read 0.

Source files
------------

// File: rtl/md_bus_pkg.sv
// rtl/md_bus_pkg.sv - shared types and constants for the Mega Drive bus front end
package md_bus_pkg;

  localparam int CNT_W = 16;
  localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    DECODE,
    WAIT_ACK,
    HOLD
  } state_t;

  typedef enum logic [1:0] {
    REGION_CE_LO = 2'd0,
    REGION_CE_HI = 2'd1,
    REGION_CAS   = 2'd2,
    REGION_OTHER = 2'd3
  } region_t;

  // Chip-enable priority: CE_LO wins over CE_HI, which wins over CAS alone
  function automatic region_t region_of(input logic ce_lo_n, input logic ce_hi_n,
                                        input logic cas_n);
    if (!ce_lo_n)      return REGION_CE_LO;
    else if (!ce_hi_n) return REGION_CE_HI;
    else if (!cas_n)   return REGION_CAS;
    else               return REGION_OTHER;
  endfunction

endpackage

// File: rtl/md_sync_edge.sv
// rtl/md_sync_edge.sv - multi-flop strobe synchroniser with fall/rise pulses
module md_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_level,
  output logic o_fall,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the raw strobe through the chain (idle-high) and remember the last synced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_level = r_sync[STAGES-1];
  assign o_fall  = r_prev & ~r_sync[STAGES-1];
  assign o_rise  = ~r_prev & r_sync[STAGES-1];

endmodule

// File: rtl/md_bus_front.sv
// rtl/md_bus_front.sv - MD cartridge bus front end; MD_BUS_STATS_EN adds cycle/error counters
module md_bus_front
  import md_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 2,
  parameter int ACK_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [22:0] md_addr,
  input  logic [15:0] md_dato,
  input  logic        md_as_n,
  input  logic        md_cas_n,
  input  logic        md_ce_lo_n,
  input  logic        md_ce_hi_n,
  input  logic        md_oe_n,
  input  logic        md_we_lo_n,
  input  logic        md_we_hi_n,
  output logic [15:0] md_dati,
  output logic        md_bus_oe,
  output logic        md_dtak,
  output logic        req_rd,
  output logic        req_wr,
  output logic [23:0] req_addr,
  output logic [15:0] req_data,
  output logic [1:0]  req_be,
  output logic [1:0]  req_region,
  input  logic        core_ack,
  input  logic [15:0] core_rdata,
  output logic        err_timeout,
  output logic        err_abort
`ifdef MD_BUS_STATS_EN
  ,
  output logic [15:0] stat_rd,
  output logic [15:0] stat_wr,
  output logic [15:0] stat_err
`endif
);

  // The IDLE cycle that detects the AS fall counts as the first settle cycle,
  // which keeps pin-to-request latency at SYNC_STAGES+SETTLE_CYC+1.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYC > 2) ? SETTLE_CYC - 2 : 0);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(ACK_TIMEOUT - 1);

  logic w_as_n, w_as_fall, w_as_rise;
  logic [5:0] w_lvl, w_unused_fall, w_unused_rise;
  logic w_cas_n, w_ce_lo_n, w_ce_hi_n, w_oe_n, w_we_lo_n, w_we_hi_n;

  md_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_as (
    .clk(clk), .rst_n(rst_n), .i_d(md_as_n),
    .o_level(w_as_n), .o_fall(w_as_fall), .o_rise(w_as_rise)
  );

  logic [5:0] w_raw;
  assign w_raw = {md_cas_n, md_ce_lo_n, md_ce_hi_n, md_oe_n, md_we_lo_n, md_we_hi_n};

  for (genvar g = 0; g < 6; g++) begin : g_sync
    md_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(clk), .rst_n(rst_n), .i_d(w_raw[g]),
      .o_level(w_lvl[g]), .o_fall(w_unused_fall[g]), .o_rise(w_unused_rise[g])
    );
  end

  assign {w_cas_n, w_ce_lo_n, w_ce_hi_n, w_oe_n, w_we_lo_n, w_we_hi_n} = w_lvl;

  logic w_rd_cond, w_wr_cond;
  assign w_rd_cond = ~w_oe_n & (~w_ce_lo_n | ~w_ce_hi_n | ~w_cas_n);
  assign w_wr_cond = ~w_we_lo_n | ~w_we_hi_n;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_aborted, r_is_rd;
  logic             w_do_rd, w_do_wr, w_do_ack, w_do_tmo, w_do_abort, w_cnt_clr;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and per-cycle action strobes
  always_comb begin
    w_state_nxt = r_state;
    w_do_rd     = 1'b0;
    w_do_wr     = 1'b0;
    w_do_ack    = 1'b0;
    w_do_tmo    = 1'b0;
    w_do_abort  = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_as_fall) begin
          w_state_nxt = SETTLE;
          w_cnt_clr   = 1'b1;
        end
      end
      SETTLE: begin
        if (r_cnt == SETTLE_LAST) w_state_nxt = DECODE;
      end
      DECODE: begin
        if (w_as_n) begin
          w_state_nxt = IDLE;
        end else if (w_rd_cond) begin
          w_do_rd     = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = WAIT_ACK;
        end else if (w_wr_cond) begin
          w_do_wr     = 1'b1;
          w_cnt_clr   = 1'b1;
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        w_do_abort = w_as_n & ~r_aborted;
        if (core_ack)               w_do_ack = 1'b1;
        else if (r_cnt == TMO_LAST) w_do_tmo = 1'b1;
        if (w_do_ack | w_do_tmo)
          w_state_nxt = (w_as_n | r_aborted) ? IDLE : HOLD;
      end
      HOLD: begin
        if (w_as_rise | w_as_n) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shared settle/timeout counter and abort tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_aborted <= 1'b0;
    end else begin
      if (w_cnt_clr)                                     r_cnt <= '0;
      else if (r_state == SETTLE || r_state == WAIT_ACK) r_cnt <= r_cnt + CNT_W'(1);
      if (w_do_rd | w_do_wr) r_aborted <= 1'b0;
      else if (w_do_abort)   r_aborted <= 1'b1;
    end
  end

  // Request/response datapath: pulses each cycle, latched fields hold until the next request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_rd      <= 1'b0;
      req_wr      <= 1'b0;
      err_timeout <= 1'b0;
      err_abort   <= 1'b0;
      req_addr    <= '0;
      req_data    <= '0;
      req_be      <= '0;
      req_region  <= '0;
      r_is_rd     <= 1'b0;
      md_dati     <= 16'h0000;
    end else begin
      req_rd      <= w_do_rd;
      req_wr      <= w_do_wr;
      err_timeout <= w_do_tmo;
      err_abort   <= w_do_abort;
      if (w_do_rd | w_do_wr) begin
        req_addr   <= {md_addr, 1'b0};
        req_region <= region_of(w_ce_lo_n, w_ce_hi_n, w_cas_n);
        r_is_rd    <= w_do_rd;
      end
      if (w_do_rd) req_be <= 2'b11;
      if (w_do_wr) begin
        req_be   <= {~w_we_hi_n, ~w_we_lo_n};
        req_data <= md_dato;
      end
      if (w_do_ack && r_is_rd) md_dati <= core_rdata;
      else if (w_do_tmo)       md_dati <= TIMEOUT_DATA;
    end
  end

  // Bus handshake drops combinationally in the cycle the synced AS goes high
  assign md_dtak   = (r_state == HOLD) & ~w_as_n;
  assign md_bus_oe = (r_state == HOLD) & ~w_as_n & r_is_rd & ~w_oe_n;

`ifdef MD_BUS_STATS_EN
  logic [15:0] r_stat_rd, r_stat_wr, r_stat_err;

  // Saturating activity counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_rd  <= '0;
      r_stat_wr  <= '0;
      r_stat_err <= '0;
    end else begin
      if (req_rd && r_stat_rd != 16'hFFFF) r_stat_rd <= r_stat_rd + 16'd1;
      if (req_wr && r_stat_wr != 16'hFFFF) r_stat_wr <= r_stat_wr + 16'd1;
      if ((err_timeout | err_abort) && r_stat_err != 16'hFFFF) r_stat_err <= r_stat_err + 16'd1;
    end
  end

  assign stat_rd  = r_stat_rd;
  assign stat_wr  = r_stat_wr;
  assign stat_err = r_stat_err;
`endif

endmodule

// File: tb/tb_md_bus_front.sv
// tb/tb_md_bus_front.sv - directed self-checking bench for md_bus_front
module tb_md_bus_front;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [22:0] md_addr;
  logic [15:0] md_dato;
  logic        md_as_n, md_cas_n, md_ce_lo_n, md_ce_hi_n, md_oe_n, md_we_lo_n, md_we_hi_n;
  logic [15:0] md_dati;
  logic        md_bus_oe, md_dtak, req_rd, req_wr;
  logic [23:0] req_addr;
  logic [15:0] req_data;
  logic [1:0]  req_be, req_region;
  logic        core_ack;
  logic [15:0] core_rdata;
  logic        err_timeout, err_abort;
`ifdef MD_BUS_STATS_EN
  logic [15:0] stat_rd, stat_wr, stat_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  md_bus_front dut (
    .clk(clk), .rst_n(rst_n), .md_addr(md_addr), .md_dato(md_dato),
    .md_as_n(md_as_n), .md_cas_n(md_cas_n), .md_ce_lo_n(md_ce_lo_n),
    .md_ce_hi_n(md_ce_hi_n), .md_oe_n(md_oe_n), .md_we_lo_n(md_we_lo_n),
    .md_we_hi_n(md_we_hi_n), .md_dati(md_dati), .md_bus_oe(md_bus_oe),
    .md_dtak(md_dtak), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_data(req_data), .req_be(req_be), .req_region(req_region),
    .core_ack(core_ack), .core_rdata(core_rdata), .err_timeout(err_timeout),
    .err_abort(err_abort)
`ifdef MD_BUS_STATS_EN
    , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_err(stat_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    md_as_n = 1'b1; md_cas_n = 1'b1; md_ce_lo_n = 1'b1; md_ce_hi_n = 1'b1;
    md_oe_n = 1'b1; md_we_lo_n = 1'b1; md_we_hi_n = 1'b1;
  endtask

  int n_abort, n_dtak, n_tmo, n_req;

  initial begin
    rst_n = 1'b0; md_addr = '0; md_dato = '0; core_ack = 1'b0; core_rdata = '0;
    bus_idle();
    tick(3);
    check("rst_dati", md_dati, 32'h0);
    check("rst_dtak", md_dtak, 32'h0);
    check("rst_oe", md_bus_oe, 32'h0);
    check("rst_req", {req_rd, req_wr, err_timeout, err_abort}, 32'h0);
    rst_n = 1'b1;
    tick(3);

    // Read from CE_LO, OE asserted late, ack three cycles after the request
    md_addr = 23'h000100; md_as_n = 1'b0; md_ce_lo_n = 1'b0;
    tick(6);
    check("rd_wait_oe", req_rd, 32'h0);
    md_oe_n = 1'b0;
    tick(2);
    check("rd_early", req_rd, 32'h0);
    tick(1);
    check("rd_pulse", req_rd, 32'h1);
    check("rd_addr", req_addr, 32'h000200);
    check("rd_region", req_region, 32'h0);
    check("rd_be", req_be, 32'h3);
    tick(1);
    check("rd_one_cycle", req_rd, 32'h0);
    tick(1);
    core_ack = 1'b1; core_rdata = 16'hA55A;
    tick(1);
    core_ack = 1'b0; core_rdata = 16'h0;
    check("rd_dtak", md_dtak, 32'h1);
    check("rd_bus_oe", md_bus_oe, 32'h1);
    check("rd_dati", md_dati, 32'hA55A);
    bus_idle();
    tick(1);
    check("rd_dtak_hold", md_dtak, 32'h1);
    tick(1);
    check("rd_dtak_drop", md_dtak, 32'h0);
    check("rd_oe_drop", md_bus_oe, 32'h0);
    tick(3);

    // Stray ack while idle must not touch md_dati
    core_ack = 1'b1; core_rdata = 16'h5555;
    tick(1);
    core_ack = 1'b0;
    tick(1);
    check("idle_ack_ignored", md_dati, 32'hA55A);

    // Low-byte write to CE_HI: request exactly 5 cycles after AS falls
    md_addr = 23'h012345; md_dato = 16'h00C3;
    md_as_n = 1'b0; md_ce_hi_n = 1'b0; md_we_lo_n = 1'b0;
    tick(4);
    check("wr_latency_early", req_wr, 32'h0);
    tick(1);
    check("wr_pulse", req_wr, 32'h1);
    check("wr_be", req_be, 32'h1);
    check("wr_data", req_data, 32'h00C3);
    check("wr_region", req_region, 32'h1);
    check("wr_addr", req_addr, 32'h02468A);
    core_ack = 1'b1; core_rdata = 16'h1234;
    tick(1);
    core_ack = 1'b0;
    check("wr_dtak", md_dtak, 32'h1);
    check("wr_no_oe", md_bus_oe, 32'h0);
    check("wr_dati_held", md_dati, 32'hA55A);
    bus_idle();
    tick(4);
    check("wr_dtak_drop", md_dtak, 32'h0);

    // CAS-only read with no ack: timeout exactly 32 cycles after req_rd
    md_addr = 23'h7FFFFF; md_as_n = 1'b0; md_cas_n = 1'b0; md_oe_n = 1'b0;
    tick(5);
    check("tmo_req", req_rd, 32'h1);
    check("tmo_region", req_region, 32'h2);
    check("tmo_addr", req_addr, 32'hFFFFFE);
    tick(31);
    check("tmo_early", err_timeout, 32'h0);
    tick(1);
    check("tmo_pulse", err_timeout, 32'h1);
    check("tmo_dati", md_dati, 32'hFFFF);
    check("tmo_dtak", md_dtak, 32'h1);
    tick(1);
    check("tmo_one_cycle", err_timeout, 32'h0);
    check("tmo_dtak_held", md_dtak, 32'h1);
    bus_idle();
    tick(2);
    check("tmo_dtak_drop", md_dtak, 32'h0);
    tick(3);

    // High-byte write aborted: AS released 2 cycles after req_wr, ack 4 cycles later
    md_addr = 23'h000010; md_dato = 16'hBE00;
    md_as_n = 1'b0; md_ce_lo_n = 1'b0; md_we_hi_n = 1'b0;
    tick(5);
    check("ab_req", req_wr, 32'h1);
    check("ab_be", req_be, 32'h2);
    tick(2);
    bus_idle();
    n_abort = 0; n_dtak = 0; n_tmo = 0;
    for (int i = 0; i < 12; i++) begin
      core_ack = (i == 4);
      tick(1);
      n_abort += int'(err_abort);
      n_dtak  += int'(md_dtak);
      n_tmo   += int'(err_timeout);
    end
    core_ack = 1'b0;
    check("ab_pulses", n_abort, 32'd1);
    check("ab_no_dtak", n_dtak, 32'd0);
    check("ab_no_tmo", n_tmo, 32'd0);

    // One-cycle AS glitch: no request and no error
    md_as_n = 1'b0;
    tick(1);
    md_as_n = 1'b1;
    n_req = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_req += int'(req_rd) + int'(req_wr) + int'(err_timeout) + int'(err_abort);
    end
    check("glitch_quiet", n_req, 32'd0);

    // Reset during HOLD drops the handshake immediately
    md_addr = 23'h000020; md_as_n = 1'b0; md_ce_lo_n = 1'b0; md_oe_n = 1'b0;
    tick(5);
    core_ack = 1'b1; core_rdata = 16'h7E57;
    tick(1);
    core_ack = 1'b0;
    check("rst_hold_dtak", md_dtak, 32'h1);
    check("rst_hold_oe", md_bus_oe, 32'h1);
`ifdef MD_BUS_STATS_EN
    check("stat_rd", stat_rd, 32'd3);
    check("stat_wr", stat_wr, 32'd2);
    check("stat_err", stat_err, 32'd2);
`endif
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_dtak", md_dtak, 32'h0);
    check("async_rst_oe", md_bus_oe, 32'h0);
    check("async_rst_dati", md_dati, 32'h0);
`ifdef MD_BUS_STATS_EN
    check("stat_rst", {stat_rd, stat_wr} | {16'h0, stat_err}, 32'h0);
`endif
    bus_idle();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_dtak", md_dtak, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
